// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side blocks.
package fifo_pkg;

    localparam int DEF_DATA_W = 128;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus valid/ready stream, seen from the streamer (master) side.
interface fifo_rd_streamer_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              o_rden;
    logic [DATA_W-1:0] i_rddata;
    logic              i_empty;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              i_ready;

    modport master (
        output o_rden,
        input  i_rddata,
        input  i_empty,
        output o_valid,
        output o_data,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_rden,
        output i_rddata,
        output i_empty,
        input  o_valid,
        input  o_data,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Small circular buffer holding read data until the consumer takes it.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2,
    localparam int PTR_W = clog2(DEPTH),
    localparam int OCC_W = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [OCC_W-1:0]  occ,
    output logic [DATA_W-1:0] head_data
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [OCC_W-1:0]  occ_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Flush wins over a capture on the same edge.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            if (push) tail_reg <= ptr_inc(tail_reg);
            if (pop)  head_reg <= ptr_inc(head_reg);
            occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push && !flush) mem[tail_reg] <= push_data;
    end

    assign occ       = occ_reg;
    assign head_data = (occ_reg != '0) ? mem[head_reg] : '0;

    assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && !flush && occ_reg == OCC_W'(DEPTH)));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side streamer for the synchronous FIFO: credit-limited reads, latency
// absorbed in a skid buffer, packet framing and a running beat counter.
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2,
    parameter int PKT_LEN   = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_en,
    input  logic               i_flush,
    fifo_rd_streamer_if.master bus,
    output logic [CNT_W-1:0]   o_beat_cnt,
    output logic               o_busy
);
    localparam int OCC_W  = clog2(BUF_DEPTH + 1);
    localparam int INFL_W = clog2(RD_LAT + 1);
    localparam int CRD_W  = clog2(BUF_DEPTH + RD_LAT + 2);
    localparam int IDX_W  = (PKT_LEN > 1) ? clog2(PKT_LEN) : 1;

    logic [RD_LAT-1:0] issued_reg;
    logic [RD_LAT-1:0] keep_reg;
    logic [OCC_W-1:0]  occ;
    logic [INFL_W-1:0] infl;
    logic [CRD_W-1:0]  credit_used;
    logic              pop;
    logic              rden;
    logic              capture;
    logic              last_beat;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;
    logic [DATA_W-1:0] head_data;

    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            infl = infl + INFL_W'(issued_reg[i]);
        end
    end

    // A read may be issued only if the word it returns is guaranteed a slot,
    // counting the slot freed by this cycle's pop.
    assign pop         = bus.o_valid & bus.i_ready;
    assign credit_used = CRD_W'(occ) + CRD_W'(infl) - CRD_W'(pop);
    assign rden        = rstn & i_en & ~bus.i_empty & ~i_flush
                         & (credit_used < CRD_W'(BUF_DEPTH));
    assign capture     = keep_reg[RD_LAT-1];
    assign last_beat   = (idx_reg == IDX_W'(PKT_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            issued_reg   <= '0;
            keep_reg     <= '0;
            idx_reg      <= '0;
            beat_cnt_reg <= '0;
        end else begin
            issued_reg[0] <= rden;
            keep_reg[0]   <= rden;
            for (int i = 1; i < RD_LAT; i++) begin
                issued_reg[i] <= issued_reg[i-1];
                keep_reg[i]   <= keep_reg[i-1] & ~i_flush;
            end
            if (pop) beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (i_flush) begin
                idx_reg <= '0;
            end else if (pop) begin
                idx_reg <= last_beat ? '0 : idx_reg + IDX_W'(1);
            end
        end
    end

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_skid_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (capture),
        .push_data (bus.i_rddata),
        .pop       (pop),
        .flush     (i_flush),
        .occ       (occ),
        .head_data (head_data)
    );

    assign bus.o_rden  = rden;
    assign bus.o_valid = (occ != '0);
    assign bus.o_data  = head_data;
    assign bus.o_last  = bus.o_valid & last_beat;
    assign o_beat_cnt  = beat_cnt_reg;
    assign o_busy      = (occ != '0) | (|issued_reg);

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench: FIFO model with one-cycle read latency feeding the streamer.
module tb_fifo_rd_streamer;
    logic       clk = 1'b0;
    logic       rstn;
    logic       i_en;
    logic       i_flush;
    logic [3:0] o_beat_cnt;
    logic       o_busy;

    int checks = 0;
    int errors = 0;
    int rden_cnt = 0;
    int pop_cnt = 0;
    int empty_reads = 0;
    int wr_ptr = 0;
    int rd_ptr = 0;
    int snap_pop;
    int snap_rden;
    logic [15:0] fmem [64];
    logic [15:0] rddata_q = '0;
    logic [15:0] bp_data [16];
    logic [15:0] bp_rden;
    logic [15:0] bp_valid;
    logic [15:0] exp_data;

    fifo_rd_streamer_if #(.DATA_W(16)) bus ();

    fifo_rd_streamer #(
        .DATA_W(16), .RD_LAT(1), .BUF_DEPTH(2), .PKT_LEN(4), .CNT_W(4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_en       (i_en),
        .i_flush    (i_flush),
        .bus        (bus),
        .o_beat_cnt (o_beat_cnt),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    assign bus.i_empty  = (rd_ptr == wr_ptr);
    assign bus.i_rddata = rddata_q;

    always @(posedge clk) begin
        if (bus.o_rden) begin
            rddata_q <= fmem[rd_ptr % 64];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.o_rden) rden_cnt++;
        if (bus.o_rden && bus.i_empty) empty_reads++;
        if (rstn && bus.o_valid && bus.i_ready) pop_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_end();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr % 64] = 16'(base + i);
            wr_ptr++;
        end
    endtask

    initial begin
        rstn = 1'b0;
        i_en = 1'b0;
        i_flush = 1'b0;
        bus.i_ready = 1'b0;
        step_end();

        // Reset state
        @(negedge clk);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_last", bus.o_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_cnt", o_beat_cnt, 0);
        step_end();
        load(32'h10, 8);
        i_en = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        chk("rst_rden_forced", bus.o_rden, 0);
        step_end();
        rstn = 1'b1;

        // Streaming
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("s_rden", bus.o_rden, (k < 8));
            chk("s_valid", bus.o_valid, (k >= 2 && k < 10));
            if (k >= 2 && k < 10) chk("s_data", bus.o_data, 16'(16'h10 + k - 2));
            chk("s_last", bus.o_last, (k == 5 || k == 9));
            step_end();
        end
        @(negedge clk);
        chk("s_cnt", o_beat_cnt, 8);
        chk("s_busy", o_busy, 0);
        step_end();

        // Backpressure: ready low for 5 cycles after the first beat
        bp_data = '{16'h00, 16'h00, 16'h20, 16'h21, 16'h21, 16'h21, 16'h21, 16'h21,
                    16'h21, 16'h22, 16'h23, 16'h24, 16'h25, 16'h26, 16'h27, 16'h00};
        bp_rden  = 16'b0001_1111_0000_0111;
        bp_valid = 16'h7FFC;
        snap_pop = pop_cnt;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) load(32'h20, 8);
            bus.i_ready = !(k >= 3 && k <= 7);
            @(negedge clk);
            chk("bp_rden", bus.o_rden, bp_rden[k]);
            chk("bp_valid", bus.o_valid, bp_valid[k]);
            if (bp_valid[k]) chk("bp_data", bus.o_data, bp_data[k]);
            chk("bp_last", bus.o_last, (k == 10 || k == 14));
            step_end();
        end
        chk("bp_pops", pop_cnt - snap_pop, 8);
        chk("bp_cnt_wrap", o_beat_cnt, 0);

        // Empty boundary: single word
        snap_rden = rden_cnt;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) load(32'hAA, 1);
            @(negedge clk);
            chk("e_rden", bus.o_rden, (k == 0));
            chk("e_valid", bus.o_valid, (k == 2));
            if (k == 2) chk("e_data", bus.o_data, 16'hAA);
            step_end();
        end
        chk("e_pulses", rden_cnt - snap_rden, 1);
        chk("e_cnt", o_beat_cnt, 1);

        // Flush with one buffered word, one read in flight and a same-cycle pop
        for (int k = 0; k < 12; k++) begin
            if (k == 0) load(32'h30, 8);
            i_flush = (k == 3);
            @(negedge clk);
            chk("f_rden", bus.o_rden, (k <= 2 || (k >= 4 && k <= 8)));
            chk("f_valid", bus.o_valid, (k == 2 || k == 3 || (k >= 6 && k <= 10)));
            exp_data = (k <= 3) ? 16'(16'h30 + k - 2) : 16'(16'h33 + k - 6);
            if (k == 2 || k == 3 || (k >= 6 && k <= 10)) chk("f_data", bus.o_data, exp_data);
            chk("f_last", bus.o_last, (k == 9));
            if (k == 3) chk("f_busy_pre", o_busy, 1);
            if (k == 4) chk("f_busy_post", o_busy, 0);
            step_end();
        end
        i_flush = 1'b0;
        chk("f_cnt", o_beat_cnt, 8);

        // Reset mid-stream with two buffered words
        for (int k = 0; k < 13; k++) begin
            if (k == 0) load(32'h40, 8);
            rstn = (k != 3);
            bus.i_ready = (k >= 3);
            @(negedge clk);
            chk("r_rden", bus.o_rden, (k <= 1 || (k >= 4 && k <= 9)));
            chk("r_valid", bus.o_valid, (k == 2 || k == 3 || (k >= 6 && k <= 11)));
            exp_data = (k <= 3) ? 16'h40 : 16'(16'h42 + k - 6);
            if (k == 2 || k == 3 || (k >= 6 && k <= 11)) chk("r_data", bus.o_data, exp_data);
            chk("r_last", bus.o_last, (k == 9));
            if (k == 4) begin
                chk("r_busy", o_busy, 0);
                chk("r_data0", bus.o_data, 0);
                chk("r_cnt0", o_beat_cnt, 0);
            end
            step_end();
        end
        chk("r_cnt", o_beat_cnt, 6);

        // Counter wrap over 17 beats, i_en paused mid-stream
        rstn = 1'b0;
        i_en = 1'b0;
        step_end();
        snap_pop = pop_cnt;
        for (int k = 0; k < 23; k++) begin
            if (k == 0) begin
                rstn = 1'b1;
                load(32'h50, 17);
            end
            i_en = !(k >= 4 && k <= 6);
            @(negedge clk);
            if (k == 0) chk("w_cnt0", o_beat_cnt, 0);
            chk("w_rden", bus.o_rden, (k <= 3 || (k >= 7 && k <= 19)));
            chk("w_valid", bus.o_valid, ((k >= 2 && k <= 5) || (k >= 9 && k <= 21)));
            exp_data = (k <= 5) ? 16'(16'h50 + k - 2) : 16'(16'h54 + k - 9);
            if ((k >= 2 && k <= 5) || (k >= 9 && k <= 21)) chk("w_data", bus.o_data, exp_data);
            step_end();
        end
        @(negedge clk);
        chk("w_cnt_wrap", o_beat_cnt, 1);
        chk("w_busy", o_busy, 0);
        chk("w_pops", pop_cnt - snap_pop, 17);
        chk("no_empty_reads", empty_reads, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
